// File: rtl/operand_fetch_pkg.sv
// rtl/operand_fetch_pkg.sv - shared register-file geometry for the operand fetch stage
package operand_fetch_pkg;

  localparam int NUM_REGS   = 4;
  localparam int DATA_WIDTH = 36;
  localparam int OP_WIDTH   = 6;
  localparam int ADDR_WIDTH = $clog2(NUM_REGS);

endpackage

// File: rtl/operand_fetch_reg_scoreboard.sv
// rtl/operand_fetch_reg_scoreboard.sv - per-register busy bits awaiting writeback
module reg_scoreboard
  import operand_fetch_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_set_en,
  input  logic [ADDR_WIDTH-1:0] i_set_idx,
  input  logic                  i_clr_en,
  input  logic [ADDR_WIDTH-1:0] i_clr_idx,
  input  logic                  i_flush_clr_en,
  input  logic [ADDR_WIDTH-1:0] i_flush_clr_idx,
  input  logic [ADDR_WIDTH-1:0] i_rd_idx_a,
  input  logic [ADDR_WIDTH-1:0] i_rd_idx_b,
  input  logic [ADDR_WIDTH-1:0] i_rd_idx_c,
  output logic                  o_busy_a,
  output logic                  o_busy_b,
  output logic                  o_busy_c
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // Set is applied last so a new producer wins over a same-edge clear.
  always_comb begin
    busy_d = busy_q;
    if (i_clr_en)       busy_d[i_clr_idx]       = 1'b0;
    if (i_flush_clr_en) busy_d[i_flush_clr_idx] = 1'b0;
    if (i_set_en)       busy_d[i_set_idx]       = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) busy_q <= '0;
    else          busy_q <= busy_d;
  end

  assign o_busy_a = busy_q[i_rd_idx_a];
  assign o_busy_b = busy_q[i_rd_idx_b];
  assign o_busy_c = busy_q[i_rd_idx_c];

endmodule

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - register-read stage with busy scoreboard; OPERAND_FETCH_BYPASS_EN adds wb bypass
module operand_fetch
  import operand_fetch_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_flush,
  input  logic                  i_dec_valid,
  output logic                  o_dec_ready,
  input  logic [OP_WIDTH-1:0]   i_dec_op,
  input  logic [ADDR_WIDTH-1:0] i_dec_rs1,
  input  logic [ADDR_WIDTH-1:0] i_dec_rs2,
  input  logic                  i_dec_use_rs1,
  input  logic                  i_dec_use_rs2,
  input  logic [ADDR_WIDTH-1:0] i_dec_rd,
  input  logic                  i_dec_wr_rd,
  output logic [ADDR_WIDTH-1:0] o_rf_rs1,
  output logic [ADDR_WIDTH-1:0] o_rf_rs2,
  input  logic [DATA_WIDTH-1:0] i_rf_rs1_data,
  input  logic [DATA_WIDTH-1:0] i_rf_rs2_data,
  input  logic                  i_wb_valid,
  input  logic [ADDR_WIDTH-1:0] i_wb_rd,
  input  logic [DATA_WIDTH-1:0] i_wb_data,
  output logic                  o_ex_valid,
  input  logic                  i_ex_ready,
  output logic [OP_WIDTH-1:0]   o_ex_op,
  output logic [DATA_WIDTH-1:0] o_ex_rs1_data,
  output logic [DATA_WIDTH-1:0] o_ex_rs2_data,
  output logic [ADDR_WIDTH-1:0] o_ex_rd,
  output logic                  o_ex_wr_rd
);

  logic                  ex_valid_q, ex_valid_d;
  logic [OP_WIDTH-1:0]   ex_op_q,    ex_op_d;
  logic [DATA_WIDTH-1:0] ex_rs1_q,   ex_rs1_d;
  logic [DATA_WIDTH-1:0] ex_rs2_q,   ex_rs2_d;
  logic [ADDR_WIDTH-1:0] ex_rd_q,    ex_rd_d;
  logic                  ex_wr_q,    ex_wr_d;

  logic busy_rs1, busy_rs2, busy_rd;
  logic busy_eff_rs1, busy_eff_rs2, busy_eff_rd;
  logic [DATA_WIDTH-1:0] rs1_val, rs2_val;
  logic hazard, accept;

  assign o_rf_rs1 = i_dec_rs1;
  assign o_rf_rs2 = i_dec_rs2;

`ifdef OPERAND_FETCH_BYPASS_EN
  logic byp_rs1, byp_rs2, byp_rd;
  assign byp_rs1      = i_wb_valid & (i_wb_rd == i_dec_rs1);
  assign byp_rs2      = i_wb_valid & (i_wb_rd == i_dec_rs2);
  assign byp_rd       = i_wb_valid & (i_wb_rd == i_dec_rd);
  assign busy_eff_rs1 = busy_rs1 & ~byp_rs1;
  assign busy_eff_rs2 = busy_rs2 & ~byp_rs2;
  assign busy_eff_rd  = busy_rd  & ~byp_rd;
  assign rs1_val      = byp_rs1 ? i_wb_data : i_rf_rs1_data;
  assign rs2_val      = byp_rs2 ? i_wb_data : i_rf_rs2_data;
`else
  logic unused_wb_data;
  assign unused_wb_data = ^i_wb_data;
  assign busy_eff_rs1   = busy_rs1;
  assign busy_eff_rs2   = busy_rs2;
  assign busy_eff_rd    = busy_rd;
  assign rs1_val        = i_rf_rs1_data;
  assign rs2_val        = i_rf_rs2_data;
`endif

  // WAW is stalled too: a second writer would lose its busy mark on the first writeback.
  assign hazard = (i_dec_use_rs1 & busy_eff_rs1) |
                  (i_dec_use_rs2 & busy_eff_rs2) |
                  (i_dec_wr_rd   & busy_eff_rd);

  assign o_dec_ready = ~hazard & ~i_flush & (~ex_valid_q | i_ex_ready);
  assign accept      = i_dec_valid & o_dec_ready;

  reg_scoreboard u_sb (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_set_en        (accept & i_dec_wr_rd),
    .i_set_idx       (i_dec_rd),
    .i_clr_en        (i_wb_valid),
    .i_clr_idx       (i_wb_rd),
    .i_flush_clr_en  (i_flush & ex_valid_q & ex_wr_q),
    .i_flush_clr_idx (ex_rd_q),
    .i_rd_idx_a      (i_dec_rs1),
    .i_rd_idx_b      (i_dec_rs2),
    .i_rd_idx_c      (i_dec_rd),
    .o_busy_a        (busy_rs1),
    .o_busy_b        (busy_rs2),
    .o_busy_c        (busy_rd)
  );

  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_op_d    = ex_op_q;
    ex_rs1_d   = ex_rs1_q;
    ex_rs2_d   = ex_rs2_q;
    ex_rd_d    = ex_rd_q;
    ex_wr_d    = ex_wr_q;
    if (i_flush) begin
      ex_valid_d = 1'b0;
    end else if (accept) begin
      ex_valid_d = 1'b1;
      ex_op_d    = i_dec_op;
      ex_rs1_d   = rs1_val;
      ex_rs2_d   = rs2_val;
      ex_rd_d    = i_dec_rd;
      ex_wr_d    = i_dec_wr_rd;
    end else if (i_ex_ready) begin
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ex_valid_q <= 1'b0;
      ex_op_q    <= '0;
      ex_rs1_q   <= '0;
      ex_rs2_q   <= '0;
      ex_rd_q    <= '0;
      ex_wr_q    <= 1'b0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_op_q    <= ex_op_d;
      ex_rs1_q   <= ex_rs1_d;
      ex_rs2_q   <= ex_rs2_d;
      ex_rd_q    <= ex_rd_d;
      ex_wr_q    <= ex_wr_d;
    end
  end

  assign o_ex_valid    = ex_valid_q;
  assign o_ex_op       = ex_op_q;
  assign o_ex_rs1_data = ex_rs1_q;
  assign o_ex_rs2_data = ex_rs2_q;
  assign o_ex_rd       = ex_rd_q;
  assign o_ex_wr_rd    = ex_wr_q;

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - directed and random checks of operand_fetch against a behavioural model
module tb_operand_fetch;

`ifdef OPERAND_FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk, rst_n, flush;
  logic        dec_valid, dec_ready, use_rs1, use_rs2, wr_rd;
  logic [5:0]  op;
  logic [1:0]  rs1, rs2, rd, rf_rs1, rf_rs2, wb_rd;
  logic [35:0] rf_rs1_data, rf_rs2_data, wb_data;
  logic        wb_valid, ex_valid, ex_ready, ex_wr_rd;
  logic [5:0]  ex_op;
  logic [35:0] ex_rs1_data, ex_rs2_data;
  logic [1:0]  ex_rd;

  logic [35:0] rf [4];
  assign rf_rs1_data = rf[rf_rs1];
  assign rf_rs2_data = rf[rf_rs2];

  operand_fetch dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
    .i_dec_valid(dec_valid), .o_dec_ready(dec_ready), .i_dec_op(op),
    .i_dec_rs1(rs1), .i_dec_rs2(rs2), .i_dec_use_rs1(use_rs1), .i_dec_use_rs2(use_rs2),
    .i_dec_rd(rd), .i_dec_wr_rd(wr_rd),
    .o_rf_rs1(rf_rs1), .o_rf_rs2(rf_rs2), .i_rf_rs1_data(rf_rs1_data), .i_rf_rs2_data(rf_rs2_data),
    .i_wb_valid(wb_valid), .i_wb_rd(wb_rd), .i_wb_data(wb_data),
    .o_ex_valid(ex_valid), .i_ex_ready(ex_ready), .o_ex_op(ex_op),
    .o_ex_rs1_data(ex_rs1_data), .o_ex_rs2_data(ex_rs2_data), .o_ex_rd(ex_rd), .o_ex_wr_rd(ex_wr_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: architectural view of the in-flight instruction and pending writers.
  bit          m_valid, m_wr;
  bit   [5:0]  m_op;
  bit   [35:0] m_rs1d, m_rs2d;
  bit   [1:0]  m_rd;
  bit   [3:0]  m_busy;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic bit pending(input logic [1:0] x);
    return m_busy[x] && !(BYP && wb_valid && wb_rd == x);
  endfunction

  function automatic bit [35:0] operand(input logic [1:0] x);
    return (BYP && wb_valid && wb_rd == x) ? wb_data : rf[x];
  endfunction

  task automatic model_reset();
    m_valid = 0; m_wr = 0; m_op = 0; m_rs1d = 0; m_rs2d = 0; m_rd = 0; m_busy = 0;
  endtask

  task automatic idle_inputs();
    flush = 0; dec_valid = 0; use_rs1 = 0; use_rs2 = 0; wr_rd = 0; op = 0;
    rs1 = 0; rs2 = 0; rd = 0; wb_valid = 0; wb_rd = 0; wb_data = 0; ex_ready = 1;
  endtask

  task automatic issue(input logic [5:0] o, input logic [1:0] a, input logic ua,
                       input logic [1:0] b, input logic ub, input logic [1:0] d, input logic w);
    dec_valid = 1; op = o; rs1 = a; use_rs1 = ua; rs2 = b; use_rs2 = ub; rd = d; wr_rd = w;
  endtask

  // One clock: check handshake at the negedge, advance the model, check state after the edge.
  task automatic cycle();
    bit hz, rdy, acc;
    bit [3:0] nb;
    bit [35:0] s1, s2;
    @(negedge clk);
    hz  = (use_rs1 && pending(rs1)) || (use_rs2 && pending(rs2)) || (wr_rd && pending(rd));
    rdy = !hz && !flush && (!m_valid || ex_ready);
    acc = dec_valid && rdy;
    check("dec_ready", dec_ready, rdy);
    check("rf_rs1", rf_rs1, rs1);
    check("rf_rs2", rf_rs2, rs2);
    s1 = operand(rs1);
    s2 = operand(rs2);
    nb = m_busy;
    if (wb_valid) nb[wb_rd] = 0;
    if (flush && m_valid && m_wr) nb[m_rd] = 0;
    if (acc && wr_rd) nb[rd] = 1;
    @(posedge clk);
    #1;
    m_busy = nb;
    if (flush) m_valid = 0;
    else if (acc) begin
      m_valid = 1; m_op = op; m_rs1d = s1; m_rs2d = s2; m_rd = rd; m_wr = wr_rd;
    end else if (ex_ready) m_valid = 0;
    if (wb_valid) rf[wb_rd] = wb_data;
    check("ex_valid", ex_valid, m_valid);
    if (m_valid) begin
      check("ex_op", ex_op, m_op);
      check("ex_rs1_data", ex_rs1_data, m_rs1d);
      check("ex_rs2_data", ex_rs2_data, m_rs2d);
      check("ex_rd", ex_rd, m_rd);
      check("ex_wr_rd", ex_wr_rd, m_wr);
    end
    check("busy", dut.u_sb.busy_q, m_busy);
  endtask

  initial begin
    idle_inputs();
    for (int i = 0; i < 4; i++) rf[i] = 36'h100 + 36'(i);
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_ex_valid", ex_valid, 0);
    check("reset_ex_fields", {ex_op, ex_rs1_data, ex_rs2_data, ex_rd, ex_wr_rd}, 0);
    check("reset_busy", dut.u_sb.busy_q, 0);
    rst_n = 1;

    // 1: reset asserted mid-stall discards held instruction and busy bits at once
    ex_ready = 0;
    issue(6'h01, 0, 0, 0, 0, 1, 1);
    cycle();
    issue(6'h02, 2, 1, 0, 0, 0, 0);
    cycle();
    #2 rst_n = 0;
    #1;
    model_reset();
    check("t1_async_valid", ex_valid, 0);
    check("t1_async_busy", dut.u_sb.busy_q, 0);
    #1 rst_n = 1;
    ex_ready = 1;
    cycle();
    check("t1_first_accept", ex_valid, 1);

    // 2: both sources read R1
    rf[1] = 36'h22;
    issue(6'h03, 1, 1, 1, 1, 0, 0);
    cycle();
    check("t2_rs1", ex_rs1_data, 36'h22);
    check("t2_rs2", ex_rs2_data, 36'h22);

    // 3: RAW on R2 resolved by writeback of 36'h33
    issue(6'h04, 0, 0, 0, 0, 2, 1);
    cycle();
    issue(6'h05, 2, 1, 0, 0, 1, 0);
    cycle();
    check("t3_stall", dec_ready, 0);
    cycle();
    wb_valid = 1; wb_rd = 2; wb_data = 36'h33;
    cycle();
    check("t3_wb_cycle_accept", ex_valid, BYP);
    wb_valid = 0;
    ex_ready = !BYP;
    cycle();
    check("t3_valid", ex_valid, 1);
    check("t3_operand", ex_rs1_data, 36'h33);
    dec_valid = 0; ex_ready = 1;
    cycle();

    // 4: execute back-pressure for 3 cycles
    issue(6'h06, 1, 1, 3, 1, 0, 0);
    ex_ready = 0;
    cycle();
    issue(6'h07, 0, 1, 1, 0, 0, 0);
    repeat (3) cycle();
    check("t4_held_op", ex_op, 6'h06);
    check("t4_ready_low", dec_ready, 0);
    ex_ready = 1;
    cycle();
    check("t4_drain_op", ex_op, 6'h07);
    dec_valid = 0;
    cycle();

    // 5: flush of held writer frees its destination
    ex_ready = 0;
    issue(6'h08, 0, 0, 0, 0, 3, 1);
    cycle();
    dec_valid = 0; flush = 1;
    cycle();
    check("t5_flush_valid", ex_valid, 0);
    check("t5_busy3", dut.u_sb.busy_q[3], 0);
    flush = 0; ex_ready = 1;
    issue(6'h09, 3, 1, 0, 0, 0, 0);
    cycle();
    check("t5_accept", ex_valid, 1);
    dec_valid = 0;
    cycle();

    // 6: same-edge set and clear of R0, set wins
    issue(6'h0a, 0, 0, 0, 0, 0, 1);
    wb_valid = 1; wb_rd = 0; wb_data = 36'h44;
    cycle();
    check("t6_busy0", dut.u_sb.busy_q[0], 1);
    dec_valid = 0;
    cycle();
    wb_valid = 0;

    // random traffic
    for (int n = 0; n < 400; n++) begin
      dec_valid = $urandom_range(0, 3) != 0;
      op        = 6'($urandom);
      rs1       = 2'($urandom); use_rs1 = 1'($urandom);
      rs2       = 2'($urandom); use_rs2 = 1'($urandom);
      rd        = 2'($urandom); wr_rd   = 1'($urandom);
      wb_valid  = $urandom_range(0, 2) == 0;
      wb_rd     = 2'($urandom);
      wb_data   = 36'({$urandom, $urandom});
      ex_ready  = $urandom_range(0, 3) != 0;
      flush     = $urandom_range(0, 19) == 0;
      cycle();
    end

    idle_inputs();
    cycle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
